// File: rtl/base64_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : base64_stream_encoder
// Function : LANES-wide valid/ready Base64 encoder with padding and byte count
// Revision : 1.0 - initial release
// ============================================================================
module base64_stream_encoder #(
  parameter int LANES = 8,
  parameter int CNT_W = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [24*LANES-1:0]              s_data,
  input  logic                             s_last,
  input  logic [$clog2(3*LANES+1)-1:0]     s_bytes,
  input  logic                             url_mode,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [32*LANES-1:0]              m_data,
  output logic                             m_last,
  output logic [$clog2(4*LANES+1)-1:0]     m_chars,
  output logic [CNT_W-1:0]                 msg_bytes,
  output logic                             done,
  output logic                             err
);

  localparam int c_bytes_w = $clog2(3*LANES+1);
  localparam int c_chars_w = $clog2(4*LANES+1);
  localparam logic [c_bytes_w-1:0] c_full_bytes = c_bytes_w'(3*LANES);
  localparam logic [CNT_W-1:0]     c_full_cnt   = CNT_W'(3*LANES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_MSG = 1'b1
  } state_t;

  state_t                  r_state;
  logic                    r_mode;
  logic [CNT_W-1:0]        r_count;
  logic                    r_m_valid;
  logic [32*LANES-1:0]     r_m_data;
  logic                    r_m_last;
  logic [c_chars_w-1:0]    r_m_chars;
  logic [CNT_W-1:0]        r_msg_bytes;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_mode;
  logic                    w_illegal;
  logic [c_bytes_w-1:0]    w_n_eff;
  logic [32*LANES-1:0]     w_enc;
  logic [LANES-1:0]        w_used;
  logic [c_chars_w-1:0]    w_chars;
  logic [CNT_W-1:0]        w_base;
  logic [CNT_W-1:0]        w_cnt_full;
  logic [CNT_W-1:0]        w_cnt_last;

  function automatic logic [7:0] f_b64_char(input logic [5:0] idx, input logic url);
    logic [7:0] ch;
    if (idx < 6'd26)       ch = 8'h41 + {2'b00, idx};
    else if (idx < 6'd52)  ch = 8'h47 + {2'b00, idx};
    else if (idx < 6'd62)  ch = {2'b00, idx} - 8'd4;
    else if (idx == 6'd62) ch = url ? 8'h2D : 8'h2B;
    else                   ch = url ? 8'h5F : 8'h2F;
    return ch;
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign s_ready   = !r_m_valid || m_ready;
  assign w_accept  = s_valid && s_ready;
  assign w_mode    = (r_state == ST_IDLE) ? url_mode : r_mode;
  assign w_illegal = s_last && ((s_bytes == '0) || (s_bytes > c_full_bytes));
  // Illegal byte counts are encoded as a full beat so the stream keeps flowing.
  assign w_n_eff   = (s_last && !w_illegal) ? s_bytes : c_full_bytes;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int c_lo = 3*g;
    logic [1:0]  w_vb;
    logic [23:0] w_grp;
    logic [23:0] w_msk;

    assign w_grp = s_data[24*g +: 24];

    always_comb begin
      if (w_n_eff >= c_bytes_w'(c_lo + 3))
        w_vb = 2'd3;
      else if (w_n_eff > c_bytes_w'(c_lo))
        w_vb = 2'(w_n_eff - c_bytes_w'(c_lo));
      else
        w_vb = 2'd0;
    end

    // Bytes past the message end are zeroed so they never leak into a char.
    assign w_msk = {(w_vb != 2'd0)  ? w_grp[23:16] : 8'h00,
                    (w_vb >= 2'd2)  ? w_grp[15:8]  : 8'h00,
                    (w_vb == 2'd3)  ? w_grp[7:0]   : 8'h00};

    assign w_enc[32*g +: 32] = (w_vb == 2'd0) ? 32'h0000_0000 :
                               {f_b64_char(w_msk[23:18], w_mode),
                                f_b64_char(w_msk[17:12], w_mode),
                                (w_vb >= 2'd2) ? f_b64_char(w_msk[11:6], w_mode) : 8'h3D,
                                (w_vb == 2'd3) ? f_b64_char(w_msk[5:0],  w_mode) : 8'h3D};

    assign w_used[g] = (w_vb != 2'd0);
  end

  always_comb begin
    w_chars = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_used[i]) w_chars = w_chars + c_chars_w'(4);
    end
  end

  assign w_base     = (r_state == ST_IDLE) ? '0 : r_count;
  assign w_cnt_full = f_sat_add(w_base, c_full_cnt);
  assign w_cnt_last = f_sat_add(w_base, CNT_W'(w_n_eff));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_count     <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_m_chars   <= '0;
      r_msg_bytes <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_enc;
        r_m_last  <= s_last;
        r_m_chars <= w_chars;
        if (r_state == ST_IDLE) r_mode <= url_mode;
        if (s_last) begin
          r_msg_bytes <= w_cnt_last;
          r_count     <= '0;
          r_state     <= ST_IDLE;
        end else begin
          r_count     <= w_cnt_full;
          r_state     <= ST_IN_MSG;
        end
        if (w_illegal) r_err <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign m_chars   = r_m_chars;
  assign msg_bytes = r_msg_bytes;
  assign err       = r_err;
  assign done      = r_m_valid && m_ready && r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_base64_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_base64_stream_encoder
// Function : directed self-checking bench, one LANES=1 and one LANES=8 encoder
// Revision : 1.0 - initial release
// ============================================================================
module tb_base64_stream_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // LANES=1 instance
  logic        a_s_valid, a_s_ready, a_s_last, a_url_mode;
  logic [23:0] a_s_data;
  logic [1:0]  a_s_bytes;
  logic        a_m_valid, a_m_ready, a_m_last, a_done, a_err;
  logic [31:0] a_m_data;
  logic [2:0]  a_m_chars;
  logic [31:0] a_msg_bytes;

  // LANES=8 instance
  logic         b_s_valid, b_s_ready, b_s_last, b_url_mode;
  logic [191:0] b_s_data;
  logic [4:0]   b_s_bytes;
  logic         b_m_valid, b_m_ready, b_m_last, b_done, b_err;
  logic [255:0] b_m_data;
  logic [5:0]   b_m_chars;
  logic [31:0]  b_msg_bytes;

  base64_stream_encoder #(.LANES(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_last(a_s_last), .s_bytes(a_s_bytes), .url_mode(a_url_mode),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .m_last(a_m_last), .m_chars(a_m_chars), .msg_bytes(a_msg_bytes),
    .done(a_done), .err(a_err)
  );

  base64_stream_encoder #(.LANES(8), .CNT_W(32)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_last(b_s_last), .s_bytes(b_s_bytes), .url_mode(b_url_mode),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_last(b_m_last), .m_chars(b_m_chars), .msg_bytes(b_msg_bytes),
    .done(b_done), .err(b_err)
  );

  // Stream vectors for the LANES=8 instance
  logic [191:0] in_data [4];
  logic         in_last [4];
  logic [4:0]   in_bytes[4];
  logic         in_mode [4];
  logic [255:0] ex_data [4];
  logic [5:0]   ex_chars[4];
  logic [31:0]  ex_bytes[4];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat1(input string tag, input logic [23:0] d, input logic last,
                       input logic [1:0] nb, input logic mode,
                       input logic [31:0] ed, input logic [2:0] ec, input logic [31:0] eb);
    @(negedge clk);
    a_s_data = d; a_s_last = last; a_s_bytes = nb; a_url_mode = mode; a_s_valid = 1'b1;
    #1 chk({tag, "_rdy"}, a_s_ready, 1);
    @(negedge clk);
    a_s_valid = 1'b0;
    #1;
    chk({tag, "_data"},  a_m_data, ed);
    chk({tag, "_chars"}, a_m_chars, ec);
    chk({tag, "_last"},  a_m_last, last);
    chk({tag, "_done"},  a_done, last);
    if (last) chk({tag, "_bytes"}, a_msg_bytes, eb);
  endtask

  task automatic beat8(input string tag, input logic [191:0] d, input logic last,
                       input logic [4:0] nb, input logic mode,
                       input logic [255:0] ed, input logic [5:0] ec, input logic [31:0] eb);
    @(negedge clk);
    b_s_data = d; b_s_last = last; b_s_bytes = nb; b_url_mode = mode; b_s_valid = 1'b1;
    @(negedge clk);
    b_s_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, b_m_valid, 1);
    chk({tag, "_data"},  b_m_data, ed);
    chk({tag, "_chars"}, b_m_chars, ec);
    if (last) chk({tag, "_bytes"}, b_msg_bytes, eb);
  endtask

  task automatic run_stream(input string tag, input logic stall);
    int           pi = 0;
    int           ci = 0;
    int           cyc = 0;
    logic         hold_v = 1'b0;
    logic [255:0] hold_d = '0;
    while (ci < 4 && cyc < 300) begin
      @(negedge clk);
      if (hold_v) begin
        chk({tag, "_hold_valid"}, b_m_valid, 1);
        chk({tag, "_hold_data"},  b_m_data, hold_d);
      end
      b_m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pi < 4) begin
        b_s_valid = 1'b1; b_s_data = in_data[pi]; b_s_last = in_last[pi];
        b_s_bytes = in_bytes[pi]; b_url_mode = in_mode[pi];
      end else begin
        b_s_valid = 1'b0;
      end
      #1;
      if (!stall && b_s_valid) chk({tag, "_no_bubble"}, b_s_ready, 1);
      if (b_m_valid && b_m_ready) begin
        chk({tag, "_data"},  b_m_data, ex_data[ci]);
        chk({tag, "_chars"}, b_m_chars, ex_chars[ci]);
        chk({tag, "_last"},  b_m_last, in_last[ci]);
        chk({tag, "_done"},  b_done, in_last[ci]);
        if (in_last[ci]) chk({tag, "_bytes"}, b_msg_bytes, ex_bytes[ci]);
        ci++;
      end
      if (b_s_valid && b_s_ready) pi++;
      hold_v = b_m_valid && !b_m_ready;
      hold_d = b_m_data;
      cyc++;
    end
    if (ci < 4) chk({tag, "_timeout_beats"}, ci, 4);
    @(negedge clk);
    b_s_valid = 1'b0;
    b_m_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_data[0] = {8{24'h4D616E}};
    in_last[0] = 1'b0; in_bytes[0] = 5'd0; in_mode[0] = 1'b0;
    ex_data[0] = {8{32'h5457_4675}}; ex_chars[0] = 6'd32; ex_bytes[0] = 32'd0;
    in_data[1] = {8{24'hFBFFBF}};
    in_last[1] = 1'b0; in_bytes[1] = 5'd0; in_mode[1] = 1'b1;
    ex_data[1] = {8{32'h2B2F_2B2F}}; ex_chars[1] = 6'd32; ex_bytes[1] = 32'd0;
    in_data[2] = {{6{24'hFFFFFF}}, 24'h4D61AB, 24'h4D616E};
    in_last[2] = 1'b1; in_bytes[2] = 5'd5; in_mode[2] = 1'b0;
    ex_data[2] = {{6{32'h0}}, 32'h5457_453D, 32'h5457_4675}; ex_chars[2] = 6'd8; ex_bytes[2] = 32'd53;
    in_data[3] = {{7{24'hFFFFFF}}, 24'hFBFFBF};
    in_last[3] = 1'b1; in_bytes[3] = 5'd3; in_mode[3] = 1'b1;
    ex_data[3] = {{7{32'h0}}, 32'h2D5F_2D5F}; ex_chars[3] = 6'd4; ex_bytes[3] = 32'd3;

    rst_n = 1'b0;
    a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_s_bytes = '0; a_url_mode = 1'b0; a_m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_s_bytes = '0; b_url_mode = 1'b0; b_m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", b_s_ready, 1);
    chk("rst_m_valid", b_m_valid, 0);
    chk("rst_m_data",  b_m_data, 0);
    chk("rst_m_last",  b_m_last, 0);
    chk("rst_m_chars", b_m_chars, 0);
    chk("rst_bytes",   b_msg_bytes, 0);
    chk("rst_done",    b_done, 0);
    chk("rst_err",     b_err, 0);
    chk("rst1_m_valid", a_m_valid, 0);
    rst_n = 1'b1;

    beat1("man", 24'h4D616E, 1'b1, 2'd3, 1'b0, 32'h5457_4675, 3'd4, 32'd3);
    @(negedge clk); #1;
    chk("man_done_drop",  a_done, 0);
    chk("man_valid_drop", a_m_valid, 0);
    beat1("pad2_ff", 24'h4D61FF, 1'b1, 2'd2, 1'b0, 32'h5457_453D, 3'd4, 32'd2);
    beat1("pad2_00", 24'h4D6100, 1'b1, 2'd2, 1'b0, 32'h5457_453D, 3'd4, 32'd2);
    beat1("pad1_a5", 24'h4DA55A, 1'b1, 2'd1, 1'b0, 32'h5451_3D3D, 3'd4, 32'd1);
    beat1("pad1_00", 24'h4D0000, 1'b1, 2'd1, 1'b0, 32'h5451_3D3D, 3'd4, 32'd1);
    beat1("std_alpha", 24'hFBFFBF, 1'b1, 2'd3, 1'b0, 32'h2B2F_2B2F, 3'd4, 32'd3);
    beat1("url_alpha", 24'hFBFFBF, 1'b1, 2'd3, 1'b1, 32'h2D5F_2D5F, 3'd4, 32'd3);
    beat1("hold_b1", 24'hFBFFBF, 1'b0, 2'd0, 1'b1, 32'h2D5F_2D5F, 3'd4, 32'd0);
    beat1("hold_b2", 24'hFBFFBF, 1'b0, 2'd0, 1'b0, 32'h2D5F_2D5F, 3'd4, 32'd0);
    beat1("hold_b3", 24'hFBFFBF, 1'b1, 2'd3, 1'b0, 32'h2D5F_2D5F, 3'd4, 32'd9);
    beat1("relatch", 24'hFBFFBF, 1'b1, 2'd3, 1'b0, 32'h2B2F_2B2F, 3'd4, 32'd3);

    run_stream("stall", 1'b1);
    run_stream("flow",  1'b0);

    beat8("illegal", {8{24'h4D616E}}, 1'b1, 5'd0, 1'b0, {8{32'h5457_4675}}, 6'd32, 32'd24);
    chk("illegal_err", b_err, 1);
    beat8("sticky", {{7{24'h123456}}, 24'h4D616E}, 1'b1, 5'd3, 1'b0,
          {{7{32'h0}}, 32'h5457_4675}, 6'd4, 32'd3);
    chk("sticky_err", b_err, 1);
    beat8("pre_rst", {8{24'h4D616E}}, 1'b0, 5'd0, 1'b0, {8{32'h5457_4675}}, 6'd32, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", b_m_valid, 0);
    chk("mid_rst_data",  b_m_data, 0);
    chk("mid_rst_chars", b_m_chars, 0);
    chk("mid_rst_bytes", b_msg_bytes, 0);
    chk("mid_rst_err",   b_err, 0);
    chk("mid_rst_ready", b_s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    beat8("post_rst", in_data[2], 1'b1, 5'd5, 1'b0, ex_data[2], 6'd8, 32'd5);
    chk("post_rst_last", b_m_last, 1);
    chk("post_rst_err",  b_err, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
